// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage with a single-outstanding data-memory access FSM (IDLE/BUSY).
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses fault instead of issuing.
module memory_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic [0:31] NextALUOut,
    input  logic [0:31] NextFPUOut,
    input  logic [0:31] NextRegB,
    input  logic [0:31] NextPCPlusFour,
    input  logic [0:1]  NextDInSrc,
    input  logic        NextRegWE,
    input  logic [0:5]  NextRegWAddr,
    input  logic [0:1]  NextMEMSize,
    input  logic        NextMEMWE,
    input  logic        NextExtMEM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [0:31] mem_addr,
    output logic [0:31] mem_wdata,
    output logic [0:3]  mem_be,
    input  logic [0:31] mem_rdata,
    input  logic        mem_ack,
    output logic [0:31] MemOut,
    output logic [0:31] ALUOut,
    output logic [0:31] FPUOut,
    output logic [0:31] PCPlusFour,
    output logic [0:1]  DInSrc,
    output logic        RegWE,
    output logic [0:5]  RegWAddr,
    output logic        MemStall,
    output logic        MisalignFault,
    output logic        dbg_state_o
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state_q;
    logic [0:31] alu_out_q, fpu_out_q, reg_b_q, pc_plus_four_q, mem_out_q;
    logic [0:1]  din_src_q, mem_size_q;
    logic [0:5]  reg_waddr_q;
    logic        reg_we_q, mem_we_q, ext_mem_q, misalign_q;

    logic        next_access, next_misalign, load_en, busy;
    logic [0:1]  lane;
    logic [0:7]  rd_byte;
    logic [0:15] rd_half;
    logic [0:31] mem_out_d, wdata;
    logic [0:3]  be;

    assign next_access = NextMEMWE | (NextDInSrc == 2'b01);

`ifdef MEM_MISALIGN_TRAP_EN
    assign next_misalign = next_access &&
        (((NextMEMSize == 2'b01) && NextALUOut[31]) ||
         (NextMEMSize[0] && (NextALUOut[30:31] != 2'b00)));
`else
    assign next_misalign = 1'b0;
`endif

    assign busy    = (state_q == BUSY);
    assign load_en = !stall_in && !busy;
    assign lane    = alu_out_q[30:31];

    // Lane selection and read extraction follow big-endian lane order: lane 0 is bits [0:7].
    always_comb begin
        rd_byte   = 8'h00;
        rd_half   = alu_out_q[30] ? mem_rdata[16:31] : mem_rdata[0:15];
        be        = 4'b1111;
        wdata     = reg_b_q;
        mem_out_d = mem_rdata;
        case (lane)
            2'b00:   rd_byte = mem_rdata[0:7];
            2'b01:   rd_byte = mem_rdata[8:15];
            2'b10:   rd_byte = mem_rdata[16:23];
            default: rd_byte = mem_rdata[24:31];
        endcase
        case (mem_size_q)
            2'b00: begin
                be        = 4'b1000 >> lane;
                wdata     = {4{reg_b_q[24:31]}};
                mem_out_d = {{24{ext_mem_q & rd_byte[0]}}, rd_byte};
            end
            2'b01: begin
                be        = alu_out_q[30] ? 4'b0011 : 4'b1100;
                wdata     = {2{reg_b_q[16:31]}};
                mem_out_d = {{16{ext_mem_q & rd_half[0]}}, rd_half};
            end
            default: begin
                be        = 4'b1111;
                wdata     = reg_b_q;
                mem_out_d = mem_rdata;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            alu_out_q      <= '0;
            fpu_out_q      <= '0;
            reg_b_q        <= '0;
            pc_plus_four_q <= '0;
            mem_out_q      <= '0;
            din_src_q      <= '0;
            mem_size_q     <= '0;
            reg_waddr_q    <= '0;
            reg_we_q       <= 1'b0;
            mem_we_q       <= 1'b0;
            ext_mem_q      <= 1'b0;
            misalign_q     <= 1'b0;
        end else if (load_en) begin
            alu_out_q      <= NextALUOut;
            fpu_out_q      <= NextFPUOut;
            reg_b_q        <= NextRegB;
            pc_plus_four_q <= NextPCPlusFour;
            din_src_q      <= NextDInSrc;
            mem_size_q     <= NextMEMSize;
            reg_waddr_q    <= NextRegWAddr;
            reg_we_q       <= NextRegWE;
            mem_we_q       <= NextMEMWE;
            ext_mem_q      <= NextExtMEM;
            misalign_q     <= next_misalign;
            state_q        <= (next_access && !next_misalign) ? BUSY : IDLE;
        end else if (busy && mem_ack) begin
            // Completion ignores stall_in; the register then holds via load_en.
            state_q <= IDLE;
            if (din_src_q == 2'b01) begin
                mem_out_q <= mem_out_d;
            end
        end
    end

    assign mem_req       = busy;
    assign MemStall      = busy;
    assign mem_we        = busy & mem_we_q;
    assign mem_addr      = busy ? {alu_out_q[0:29], 2'b00} : 32'h0;
    assign mem_be        = busy ? be : 4'b0000;
    assign mem_wdata     = busy ? wdata : 32'h0;
    assign MemOut        = mem_out_q;
    assign ALUOut        = alu_out_q;
    assign FPUOut        = fpu_out_q;
    assign PCPlusFour    = pc_plus_four_q;
    assign DInSrc        = din_src_q;
    assign RegWAddr      = reg_waddr_q;
    assign RegWE         = reg_we_q & ~busy & ~misalign_q;
    assign MisalignFault = misalign_q;
    assign dbg_state_o   = busy;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized traffic against a
// transaction-level model. Honours MEM_MISALIGN_TRAP_EN when defined.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_in = 1'b0;
  logic [0:31] n_alu = '0, n_fpu = '0, n_regb = '0, n_pc = '0;
  logic [0:1]  n_din = '0, n_size = '0;
  logic        n_regwe = 1'b0, n_memwe = 1'b0, n_ext = 1'b0;
  logic [0:5]  n_waddr = '0;
  logic [0:31] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  logic        mem_req, mem_we, RegWE, MemStall, MisalignFault, dbg_state;
  logic [0:31] mem_addr, mem_wdata, MemOut, ALUOut, FPUOut, PCPlusFour;
  logic [0:3]  mem_be;
  logic [0:1]  DInSrc;
  logic [0:5]  RegWAddr;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  memory_stage dut (
    .clk(clk), .reset(reset), .stall_in(stall_in),
    .NextALUOut(n_alu), .NextFPUOut(n_fpu), .NextRegB(n_regb), .NextPCPlusFour(n_pc),
    .NextDInSrc(n_din), .NextRegWE(n_regwe), .NextRegWAddr(n_waddr), .NextMEMSize(n_size),
    .NextMEMWE(n_memwe), .NextExtMEM(n_ext),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .MemOut(MemOut), .ALUOut(ALUOut), .FPUOut(FPUOut), .PCPlusFour(PCPlusFour),
    .DInSrc(DInSrc), .RegWE(RegWE), .RegWAddr(RegWAddr),
    .MemStall(MemStall), .MisalignFault(MisalignFault), .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] alu, fpu, regb, pc;
    logic [1:0]  din, size;
    logic        regwe, we, ext;
    logic [5:0]  waddr;
  } instr_t;

  instr_t      m_st;
  bit          m_busy, m_fault;
  logic [31:0] m_memout;

  function automatic bit is_access(instr_t i);
    return i.we || (i.din == 2'd1);
  endfunction

  function automatic bit misaligned(instr_t i);
    if (!TRAP || !is_access(i)) return 1'b0;
    if (i.size == 2'd1) return (i.alu % 2) != 0;
    if (i.size >= 2'd2) return (i.alu % 4) != 0;
    return 1'b0;
  endfunction

  // Byte offset 0 is the most significant byte of the word.
  function automatic logic [31:0] load_value(instr_t i, logic [31:0] rd);
    int unsigned off = i.alu % 4;
    logic [31:0] v;
    case (i.size)
      2'd0: begin
        v = (rd >> (8 * (3 - off))) & 32'hFF;
        if (i.ext && v >= 128) v = v + 32'hFFFFFF00;
      end
      2'd1: begin
        v = (rd >> ((off < 2) ? 16 : 0)) & 32'hFFFF;
        if (i.ext && v >= 32768) v = v + 32'hFFFF0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] lanes(instr_t i);
    int unsigned off = i.alu % 4;
    case (i.size)
      2'd0:    return 4'(1 << (3 - off));
      2'd1:    return (off < 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] store_data(instr_t i);
    case (i.size)
      2'd0:    return (i.regb & 32'hFF) * 32'h01010101;
      2'd1:    return (i.regb & 32'hFFFF) * 32'h00010001;
      default: return i.regb;
    endcase
  endfunction

  function automatic instr_t cur_next();
    instr_t i;
    i.alu = n_alu; i.fpu = n_fpu; i.regb = n_regb; i.pc = n_pc;
    i.din = n_din; i.size = n_size; i.regwe = n_regwe; i.we = n_memwe;
    i.ext = n_ext; i.waddr = n_waddr;
    return i;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st     = '{default: '0};
      m_busy   = 1'b0;
      m_fault  = 1'b0;
      m_memout = '0;
    end else if (m_busy) begin
      if (mem_ack) begin
        m_busy = 1'b0;
        if (m_st.din == 2'd1) m_memout = load_value(m_st, mem_rdata);
      end
    end else if (!stall_in) begin
      m_st    = cur_next();
      m_fault = misaligned(m_st);
      m_busy  = is_access(m_st) && !m_fault;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("MemStall", MemStall, m_busy);
      chk("mem_req", mem_req, m_busy);
      chk("state", dbg_state, m_busy);
      chk("MisalignFault", MisalignFault, m_fault);
      chk("RegWE", RegWE, m_st.regwe && !m_busy && !m_fault);
      chk("MemOut", MemOut, m_memout);
      chk("ALUOut", ALUOut, m_st.alu);
      chk("FPUOut", FPUOut, m_st.fpu);
      chk("PCPlusFour", PCPlusFour, m_st.pc);
      chk("DInSrc", DInSrc, m_st.din);
      chk("RegWAddr", RegWAddr, m_st.waddr);
      if (m_busy) begin
        chk("mem_addr", mem_addr, m_st.alu & ~32'd3);
        chk("mem_we", mem_we, m_st.we);
        chk("mem_be", mem_be, lanes(m_st));
        chk("mem_wdata", mem_wdata, store_data(m_st));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_next(input logic [31:0] alu, input logic [31:0] regb, input logic [1:0] din,
                          input logic regwe, input logic [1:0] size, input logic we, input logic ext);
    n_alu = alu; n_regb = regb; n_din = din; n_regwe = regwe;
    n_size = size; n_memwe = we; n_ext = ext;
    n_fpu = $urandom; n_pc = $urandom; n_waddr = 6'($urandom);
  endtask

  task automatic nop();
    set_next(32'h0, 32'h0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nop();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_MemOut", MemOut, 32'h0);
    chk("reset_MemStall", MemStall, 32'h0);
    chk("reset_mem_req", mem_req, 32'h0);
    chk("reset_RegWE", RegWE, 32'h0);
    chk("reset_ALUOut", ALUOut, 32'h0);
    chk("reset_mem_be", mem_be, 32'h0);
    reset = 1'b0;
    chk_en = 1'b1;

    // ALU op passes straight through one cycle after load.
    set_next(32'h12345678, 32'h0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    nop();
    chk("alu_ALUOut", ALUOut, 32'h12345678);
    chk("alu_RegWE", RegWE, 32'h1);
    chk("alu_mem_req", mem_req, 32'h0);

    // Halfword store to an upper-half address.
    set_next(32'h00000102, 32'hDEADBEEF, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0);
    tick();
    nop();
    chk("hst_mem_req", mem_req, 32'h1);
    chk("hst_mem_we", mem_we, 32'h1);
    chk("hst_mem_be", mem_be, 32'h3);
    chk("hst_mem_wdata", mem_wdata, 32'hBEEFBEEF);
    chk("hst_mem_addr", mem_addr, 32'h00000100);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("hst_done_req", mem_req, 32'h0);

    // Signed byte load, ack in the second BUSY cycle.
    set_next(32'h00001002, 32'h0, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1);
    tick();
    nop();
    chk("bld_stall1", MemStall, 32'h1);
    chk("bld_mem_be", mem_be, 32'h2);
    chk("bld_RegWE_busy", RegWE, 32'h0);
    tick();
    chk("bld_stall2", MemStall, 32'h1);
    mem_rdata = 32'h1122F344;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("bld_stall_done", MemStall, 32'h0);
    chk("bld_MemOut", MemOut, 32'hFFFFFFF3);
    chk("bld_RegWE", RegWE, 32'h1);

    // Word load with stall_in raised mid-access; ack in the third BUSY cycle.
    set_next(32'h00000020, 32'h0, 2'b01, 1'b1, 2'b10, 1'b0, 1'b0);
    tick();
    nop();
    stall_in = 1'b1;
    tick();
    tick();
    mem_rdata = 32'hCAFE0123;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("wld_done", MemStall, 32'h0);
    chk("wld_MemOut", MemOut, 32'hCAFE0123);
    set_next(32'h00000777, 32'h0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    tick();
    chk("wld_hold_ALUOut", ALUOut, 32'h00000020);
    chk("wld_hold_MemOut", MemOut, 32'hCAFE0123);
    stall_in = 1'b0;
    tick();
    nop();
    chk("wld_release_ALUOut", ALUOut, 32'h00000777);

    // Reset during BUSY discards the access; a late ack is ignored.
    set_next(32'h00000040, 32'h0, 2'b01, 1'b1, 2'b10, 1'b0, 1'b0);
    tick();
    nop();
    chk("rst_busy", mem_req, 32'h1);
    reset = 1'b1;
    #2;
    chk("rst_mem_req", mem_req, 32'h0);
    chk("rst_MemOut", MemOut, 32'h0);
    reset = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("rst_ack_req", mem_req, 32'h0);
    chk("rst_ack_state", dbg_state, 32'h0);
    chk("rst_ack_MemOut", MemOut, 32'h0);

    // Misaligned word load at 0x6.
    set_next(32'h00000006, 32'h0, 2'b01, 1'b1, 2'b10, 1'b0, 1'b0);
    tick();
    nop();
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_mem_req", mem_req, 32'h0);
    chk("mis_fault", MisalignFault, 32'h1);
    chk("mis_RegWE", RegWE, 32'h0);
    tick();
    chk("mis_fault_clear", MisalignFault, 32'h0);
`else
    chk("mis_mem_req", mem_req, 32'h1);
    chk("mis_mem_addr", mem_addr, 32'h00000004);
    chk("mis_mem_be", mem_be, 32'hF);
    chk("mis_fault", MisalignFault, 32'h0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
`endif

    // Randomized traffic, including stray acks while idle and occasional async reset pulses.
    for (int c = 0; c < 3000; c++) begin
      set_next($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      stall_in  = ($urandom_range(0, 3) == 0);
      mem_ack   = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have: clk  in  1  clock; all state updates on the rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high.
REQ-003 SHALL have: stall_in  in  1  hazard-unit hold; holds the pipeline register.
REQ-004 SHALL have: NextALUOut, NextFPUOut, NextRegB, NextPCPlusFour  in  32 each [0:31]  from the execute stage; NextALUOut is the effective address.
REQ-005 SHALL have: NextDInSrc  in  2, NextRegWE  in  1, NextRegWAddr  in  6, NextMEMSize  in  2, NextMEMWE  in  1, NextExtMEM  in  1  control from the execute stage.
REQ-006 SHALL have: mem_req, mem_we  out  1 each; mem_addr, mem_wdata  out  32 each; mem_be  out  4 [0:3]; mem_rdata  in  32; mem_ack  in  1  data-memory port.
REQ-007 SHALL have: MemOut, ALUOut, FPUOut, PCPlusFour  out  32 each; DInSrc  out  2; RegWE  out  1; RegWAddr  out  6  to writeback.
REQ-008 SHALL have: MemStall  out  1 (pipeline freeze request); MisalignFault  out  1.
REQ-009 Bit 0 SHALL be the MSB of every bus; byte lane 0 = bits [0:7] (big-endian).

Function
REQ-010 Pipeline register SHALL load all Next* inputs on a rising edge when stall_in=0 and MemStall=0; otherwise it SHALL hold.
REQ-011 A stage instruction SHALL be an access when MEMWE=1 (store) or DInSrc=2'b01 (load).
REQ-012 MEMSize encoding SHALL be 00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-013 FSM states SHALL be IDLE and BUSY; IDLE->BUSY on the same edge that loads an access; BUSY->IDLE on an edge with mem_ack=1.
REQ-014 mem_req SHALL be 1 exactly while in BUSY; mem_addr, mem_we, mem_be, mem_wdata SHALL be stable throughout BUSY.
REQ-015 MemStall SHALL equal 1 exactly while in BUSY; minimum access = 1 BUSY cycle.
REQ-016 mem_addr SHALL be ALUOut with bits [30:31] forced to 00.
REQ-017 mem_be: byte -> one lane selected by addr[30:31]; half -> lanes 0-1 (addr[30]=0) or 2-3 (addr[30]=1); word -> 1111.
REQ-018 mem_wdata: byte -> RegB[24:31] replicated 4 times; half -> RegB[16:31] replicated twice; word -> RegB.
REQ-019 On an ack edge, the selected lane(s) of mem_rdata SHALL be captured into MemOut, sign-extended if ExtMEM=1, else zero-extended; MemOut SHALL hold until the next load completes.
REQ-020 RegWE output SHALL be the registered RegWE AND NOT MemStall AND NOT MisalignFault.
REQ-021 ALUOut, FPUOut, PCPlusFour, DInSrc, RegWAddr SHALL be registered pass-throughs.
REQ-022 stall_in asserted during BUSY SHALL NOT abort the access; completion proceeds, and the register then holds until stall_in falls.
REQ-023 mem_ack while in IDLE SHALL be ignored.
REQ-024 A non-access instruction SHALL never assert mem_req.

Reset
REQ-025 reset SHALL force FSM to IDLE and clear all registered outputs to 0, including MemOut, MemStall, MisalignFault, and mem_req.
REQ-026 reset during BUSY SHALL discard the access; a late mem_ack SHALL be ignored per REQ-023.

Configuration
REQ-027 Macro MEM_MISALIGN_TRAP_EN defined: a halfword with addr[31]=1, or a word with addr[30:31]!=00, SHALL NOT enter BUSY; MisalignFault=1 while that instruction occupies the stage; RegWE is suppressed.
REQ-028 MEM_MISALIGN_TRAP_EN undefined: low address bits beyond REQ-017 SHALL be ignored and MisalignFault SHALL be tied 0.

Verification
REQ-029 Byte load, ALUOut=0x00001002, ExtMEM=1, rdata=0x1122F344, ack after 2 cycles -> be=0010, MemStall high 2 cycles, MemOut=0xFFFFFFF3.
REQ-030 Halfword store, ALUOut=0x00000102, RegB=0xDEADBEEF -> mem_we=1, be=0011, wdata=0xBEEFBEEF, addr=0x00000100.
REQ-031 Word load with stall_in raised mid-BUSY, ack in cycle 3 -> access completes, MemOut=rdata, outputs hold until stall_in=0.
REQ-032 reset pulsed during BUSY, then ack=1 -> mem_req=0, state IDLE, MemOut=0, ack ignored.
REQ-033 With MEM_MISALIGN_TRAP_EN, word load at 0x00000006 -> mem_req stays 0, MisalignFault=1, RegWE=0; without the macro -> addr 0x00000004, be=1111.
REQ-034 ALU op (DInSrc=00, MEMWE=0), ALUOut=0x12345678, RegWE=1 -> no mem_req, ALUOut and RegWE=1 at output one cycle after load.
